// File: rtl/mp_datapath.sv
// Register-file datapath: four W-bit registers, write-back mux, 8-function ALU
// and a registered Z/C/V flag set, executing one control word per clock.
module mp_datapath #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic [3:0]   ce_i,
  input  logic [2:0]   w_i,
  input  logic [1:0]   sel_i,
  input  logic [2:0]   s_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] r0_o,
  output logic [W-1:0] r1_o,
  output logic [W-1:0] r2_o,
  output logic [W-1:0] r3_o,
  output logic [W-1:0] alu_o,
  output logic         z_o,
  output logic         c_o,
  output logic         v_o
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } alu_op_e;

  logic [W-1:0] r0_q, r1_q, r2_q, r3_q;
  logic         z_q, c_q, v_q;

  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W:0]   ext_sum;
  logic [W-1:0] alu_res;
  logic         alu_c;
  logic         alu_v;
  logic [W-1:0] wb_bus;
  logic         flag_we;
  alu_op_e      op;

  assign op = alu_op_e'(s_i);

  // Operand A is any register, operand B is always the accumulator R0.
  always_comb begin
    op_a = r0_q;
    case (sel_i)
      2'd0: op_a = r0_q;
      2'd1: op_a = r1_q;
      2'd2: op_a = r2_q;
      2'd3: op_a = r3_q;
      default: op_a = r0_q;
    endcase
  end

  assign op_b = r0_q;

  always_comb begin
    ext_sum = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        ext_sum = {1'b0, op_a} + {1'b0, op_b};
        alu_res = ext_sum[W-1:0];
        alu_c   = ext_sum[W];
        alu_v   = (op_a[W-1] == op_b[W-1]) && (alu_res[W-1] != op_a[W-1]);
      end
      OP_SUB: begin
        // Carry out of A + ~B + 1 is the unsigned no-borrow (A >= B) flag.
        ext_sum = {1'b0, op_a} + {1'b0, ~op_b} + {{W{1'b0}}, 1'b1};
        alu_res = ext_sum[W-1:0];
        alu_c   = ext_sum[W];
        alu_v   = (op_a[W-1] != op_b[W-1]) && (alu_res[W-1] != op_a[W-1]);
      end
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_XOR: alu_res = op_a ^ op_b;
      OP_NOT: alu_res = ~op_a;
      OP_SHL: begin
        alu_res = {op_a[W-2:0], 1'b0};
        alu_c   = op_a[W-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, op_a[W-1:1]};
        alu_c   = op_a[0];
      end
      default: begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
      end
    endcase
  end

  always_comb begin
    wb_bus = '0;
    case (w_i)
      3'd0: wb_bus = data_i;
      3'd1: wb_bus = alu_res;
      3'd2: wb_bus = r0_q;
      3'd3: wb_bus = r1_q;
      3'd4: wb_bus = r2_q;
      3'd5: wb_bus = r3_q;
      default: wb_bus = '0;
    endcase
  end

  // Flags track only ALU results that are actually written somewhere.
  assign flag_we = (w_i == 3'd1) && (ce_i != 4'd0);

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      r0_q <= '0;
      r1_q <= '0;
      r2_q <= '0;
      r3_q <= '0;
      z_q  <= 1'b0;
      c_q  <= 1'b0;
      v_q  <= 1'b0;
    end else begin
      if (ce_i[0]) r0_q <= wb_bus;
      if (ce_i[1]) r1_q <= wb_bus;
      if (ce_i[2]) r2_q <= wb_bus;
      if (ce_i[3]) r3_q <= wb_bus;
      if (flag_we) begin
        z_q <= (alu_res == '0);
        c_q <= alu_c;
        v_q <= alu_v;
      end
    end
  end

  assign r0_o  = r0_q;
  assign r1_o  = r1_q;
  assign r2_o  = r2_q;
  assign r3_o  = r3_q;
  assign alu_o = alu_res;
  assign z_o   = z_q;
  assign c_o   = c_q;
  assign v_o   = v_q;

endmodule

// File: tb/tb_mp_datapath.sv
// Directed bench for mp_datapath: hand-computed register, ALU and flag values
// checked with immediate assertions after each clock edge.
module tb_mp_datapath;
  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         clr_i;
  logic [3:0]   ce_i;
  logic [2:0]   w_i;
  logic [1:0]   sel_i;
  logic [2:0]   s_i;
  logic [W-1:0] data_i;
  logic [W-1:0] r0_o, r1_o, r2_o, r3_o, alu_o;
  logic         z_o, c_o, v_o;

  int n_checks;
  int n_pass;
  logic [W-1:0] exp_q[$];

  mp_datapath #(.W(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (clr_i),
    .ce_i   (ce_i),
    .w_i    (w_i),
    .sel_i  (sel_i),
    .s_i    (s_i),
    .data_i (data_i),
    .r0_o   (r0_o),
    .r1_o   (r1_o),
    .r2_o   (r2_o),
    .r3_o   (r3_o),
    .alu_o  (alu_o),
    .z_o    (z_o),
    .c_o    (c_o),
    .v_o    (v_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive(input logic clr, input logic [3:0] ce, input logic [2:0] w,
                       input logic [1:0] sel, input logic [2:0] s, input logic [W-1:0] d);
    clr_i  = clr;
    ce_i   = ce;
    w_i    = w;
    sel_i  = sel;
    s_i    = s;
    data_i = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] ce, input logic [W-1:0] d);
    drive(1'b0, ce, 3'd0, 2'd0, 3'd0, d);
    tick();
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    logic [W-1:0] e;
    exp_q.push_back(expv);
    e = exp_q.pop_front();
    n_checks++;
    assert (obs === e) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, e);
  endtask

  task automatic check_regs(input string tag, input logic [W-1:0] e0, input logic [W-1:0] e1,
                            input logic [W-1:0] e2, input logic [W-1:0] e3);
    check({tag, ".r0"}, r0_o, e0);
    check({tag, ".r1"}, r1_o, e1);
    check({tag, ".r2"}, r2_o, e2);
    check({tag, ".r3"}, r3_o, e3);
  endtask

  task automatic check_flags(input string tag, input logic ez, input logic ec, input logic ev);
    check({tag, ".z"}, {7'd0, z_o}, {7'd0, ez});
    check({tag, ".c"}, {7'd0, c_o}, {7'd0, ec});
    check({tag, ".v"}, {7'd0, v_o}, {7'd0, ev});
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    // Reset overrides an all-register load.
    reset = 1'b1;
    drive(1'b0, 4'hF, 3'd0, 2'd0, 3'd0, 8'hAA);
    tick();
    tick();
    check_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00);
    check_flags("reset", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Load and move.
    load(4'b0001, 8'h05);
    check_regs("load_r0", 8'h05, 8'h00, 8'h00, 8'h00);
    drive(1'b0, 4'b0110, 3'd2, 2'd0, 3'd0, 8'hEE);
    tick();
    check_regs("move_r0", 8'h05, 8'h05, 8'h05, 8'h00);

    // Add: 20 + 70 = 90, signed overflow.
    load(4'b0001, 8'h70);
    load(4'b0010, 8'h20);
    drive(1'b0, 4'b1000, 3'd1, 2'd1, 3'd0, 8'h00);
    #1;
    check("add1.alu_pre", alu_o, 8'h90);
    tick();
    check("add1.r3", r3_o, 8'h90);
    check_flags("add1", 1'b0, 1'b0, 1'b1);

    // Add: 90 + 70 = 100 -> 00 with carry.
    load(4'b0010, 8'h90);
    drive(1'b0, 4'b1000, 3'd1, 2'd1, 3'd0, 8'h00);
    tick();
    check("add2.r3", r3_o, 8'h00);
    check_flags("add2", 1'b1, 1'b1, 1'b0);

    // Subtract with borrow, self-referencing R2.
    load(4'b0100, 8'h03);
    load(4'b0001, 8'h05);
    drive(1'b0, 4'b0100, 3'd1, 2'd2, 3'd1, 8'h00);
    tick();
    check("sub1.r2", r2_o, 8'hFE);
    check_flags("sub1", 1'b0, 1'b0, 1'b0);

    load(4'b0100, 8'h05);
    drive(1'b0, 4'b0100, 3'd1, 2'd2, 3'd1, 8'h00);
    tick();
    check("sub2.r2", r2_o, 8'h00);
    check_flags("sub2", 1'b1, 1'b1, 1'b0);

    // Shifts.
    load(4'b0010, 8'h81);
    drive(1'b0, 4'b0010, 3'd1, 2'd1, 3'd6, 8'h00);
    tick();
    check("shl.r1", r1_o, 8'h02);
    check_flags("shl", 1'b0, 1'b1, 1'b0);
    drive(1'b0, 4'b0010, 3'd1, 2'd1, 3'd7, 8'h00);
    tick();
    check("shr.r1", r1_o, 8'h01);
    check_flags("shr", 1'b0, 1'b0, 1'b0);

    // Logic ops on R3=0C against R0=05, observed combinationally.
    load(4'b1000, 8'h0C);
    drive(1'b0, 4'b0000, 3'd1, 2'd3, 3'd2, 8'h00);
    #1;
    check("and.alu", alu_o, 8'h04);
    s_i = 3'd3;
    #1;
    check("or.alu", alu_o, 8'h0D);
    s_i = 3'd4;
    #1;
    check("xor.alu", alu_o, 8'h09);

    // NOT on R1=0F.
    load(4'b0010, 8'h0F);
    drive(1'b0, 4'b0010, 3'd1, 2'd1, 3'd5, 8'h00);
    tick();
    check("not.r1", r1_o, 8'hF0);
    check_flags("not", 1'b0, 1'b0, 1'b0);

    // Zero source on bus code 6; flags hold since it is not an ALU write.
    drive(1'b0, 4'b1000, 3'd6, 2'd0, 3'd0, 8'hFF);
    tick();
    check("zero_bus.r3", r3_o, 8'h00);

    // R0 - R0 = 0 sets z and c ahead of the clear.
    drive(1'b0, 4'b0001, 3'd1, 2'd0, 3'd1, 8'h00);
    tick();
    check("self_sub.r0", r0_o, 8'h00);
    check_flags("self_sub", 1'b1, 1'b1, 1'b0);

    // Clear beats an all-register load and zeroes flags.
    drive(1'b1, 4'hF, 3'd0, 2'd0, 3'd0, 8'hFF);
    tick();
    check_regs("clr", 8'h00, 8'h00, 8'h00, 8'h00);
    check_flags("clr", 1'b0, 1'b0, 1'b0);

    // Data load of zero must not touch flags.
    load(4'b0001, 8'h00);
    check_flags("hold_load", 1'b0, 1'b0, 1'b0);

    // ALU select with no enables must not touch flags either.
    drive(1'b0, 4'b0000, 3'd1, 2'd0, 3'd0, 8'h00);
    tick();
    check_flags("hold_noce", 1'b0, 1'b0, 1'b0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mp_datapath.md
Name: mp_datapath

Overview:
- Register-file datapath of the Lab 4 microprocessor, directly downstream of the control FSM.
- Consumes the FSM control word (clear, register enables, write-source select, operand select, ALU op) every clock and executes it.
- Contains four W-bit registers, a write-back mux, an 8-function ALU and a registered flag set.
- Register and flag contents are exported for the top level and the bench.

Parameters:
W  8  data width of registers, data input and ALU

Ports:
clk        input   1    system clock, all state updates on rising edge
reset      input   1    synchronous, active-high reset
clr_i      input   1    synchronous clear of R0..R3 and flags (from FSM clr_o)
ce_i       input   4    per-register load enable, bit k loads Rk (from FSM ce_o)
w_i        input   3    write-back bus source select (from FSM w_o)
sel_i      input   2    ALU operand A register select (from FSM sel_o)
s_i        input   3    ALU operation select (from FSM s_o)
data_i     input   W    external data input
r0_o       output  W    register R0 contents
r1_o       output  W    register R1 contents
r2_o       output  W    register R2 contents
r3_o       output  W    register R3 contents
alu_o      output  W    combinational ALU result
z_o        output  1    registered zero flag
c_o        output  1    registered carry/no-borrow flag
v_o        output  1    registered signed-overflow flag

Behaviour:
- Single clock domain (clk); reset is synchronous and active-high.
- On reset: R0..R3 = 0, z_o = 0, c_o = 0, v_o = 0.
- alu_o is combinational from current register values and is not reset.
- Update priority each edge: reset > clr_i > loads.
  - clr_i=1 zeroes R0..R3 and all flags regardless of ce_i.
- Operands:
  - A = R[sel_i], B = R0 (accumulator).
  - Operand values are pre-edge values; a write becomes visible on r*_o and alu_o one cycle after the enabling edge.
- ALU by s_i (result truncated to W bits):
  - 0: A+B; c = carry out; v = signed overflow.
  - 1: A-B computed as A+~B+1; c = 1 iff A>=B unsigned; v = signed overflow.
  - 2: A&B.  3: A|B.  4: A^B.  5: ~A.
  - 6: A<<1; c = A[W-1].  7: A>>1 logical; c = A[0].
  - v = 0 for ops 2-7; c = 0 for ops 2-5.
- Write-back bus by w_i:
  - 0 = data_i
  - 1 = ALU result
  - 2..5 = R0..R3 (register move)
  - 6, 7 = all zeros
- Loads: every Rk with ce_i[k]=1 loads the bus value on the edge; multiple set bits load the same value; ce_i=0 holds all registers.
- Flags:
  - Update only on an edge where w_i=1 and ce_i != 0 (ALU write-back).
  - z = (result == 0); c and v as defined per op.
  - Otherwise the flags hold.
- Self-reference (e.g. sel_i=k, ce_i[k]=1, w_i=1) is legal and uses the old Rk.
- Reset or clr_i asserted mid-sequence takes effect on that edge; the next cycle's control word operates on zeroed state.
- No X propagation: all select codes are fully decoded.

Test Plan:
- Reset: hold reset 2 cycles with ce_i=4'hF, w_i=0, data_i=8'hAA -> R0..R3=0, z/c/v=0; reset overrides the load.
- Load and move:
  - data_i=8'h05, ce_i=0001, w_i=0 -> R0=05.
  - Next cycle w_i=2, ce_i=0110 -> R1=R2=05; R0 holds.
- Add with flags:
  - R0=8'h70, R1=8'h20, sel_i=1, s_i=0, w_i=1, ce_i=1000 -> R3=90, z=0, c=0, v=1.
  - Repeat with R1=8'h90 -> R3=00, z=1, c=1, v=0.
- Subtract / no-borrow:
  - R2=8'h03, R0=8'h05, sel_i=2, s_i=1, w_i=1, ce_i=0100 -> R2=FE, c=0.
  - Then R2=05, R0=05 -> R2=00, z=1, c=1.
- Shifts and logic:
  - R1=8'h81, sel_i=1, s_i=6, w_i=1, ce_i=0010 -> R1=02, c=1.
  - Then s_i=7 -> R1=01, c=0.
  - s_i=5 on R1=0F -> F0, c=0, v=0.
- Clear priority and flag hold:
  - clr_i=1 with ce_i=1111, w_i=0, data_i=8'hFF -> all registers and flags 0.
  - Then a w_i=0 load of 00 -> z stays 0, because the flags are not updated.
